compressed_stream_packer: RTL and testbench
===========================================

Name: compressed_stream_packer

Overview:
- Downstream of the compression front-end, which pops beats from its input FIFO and flags headers and compressible packets.
- Consumes variable-length byte chunks from the compression datapath, 0 to 32 valid bytes per cycle.
- Repacks the chunks into dense 256-bit AXI-Stream beats with tkeep and tlast, preserving packet boundaries.
- Applies backpressure upstream when the accumulator cannot absorb another chunk.

Parameters:
- BURST_WIDTH, 256: beat width in bits. Must be 256; the byte-count widths below assume 32 lanes.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  chunk valid
- in_ready  output  1  packer accepts a chunk this cycle
- in_data  input  256  chunk data; valid bytes in lanes 0..in_bytes-1, lane 0 = bits [7:0]
- in_bytes  input  6  valid byte count, 0..32
- in_last  input  1  chunk ends the packet
- m_tvalid  output  1  output beat valid
- m_tready  input  1  downstream ready
- m_tdata  output  256  packed beat, byte 0 in lane 0
- m_tkeep  output  32  lane enables, contiguous from lane 0
- m_tlast  output  1  final beat of the packet
- err_len  output  1  sticky flag: in_bytes > 32 was seen

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values:
  - acc_cnt = 0; accumulator cleared; state = FILL.
  - m_tvalid = 0, m_tlast = 0, m_tkeep = 0, err_len = 0.
  - in_ready is 1 one cycle after reset deasserts.
  - Reset mid-packet discards all buffered bytes.
- Storage: 512-bit accumulator acc holding acc_cnt bytes, acc_cnt in 0..63. The oldest byte is in lane 0.
- Chunk accept: a chunk is accepted when in_valid && in_ready.
  - Its first min(in_bytes,32) bytes are appended at byte offset acc_cnt.
  - The post-emission offset is used when an output beat fires in the same cycle.
- Length error: in_bytes > 32 is clamped to 32 and sets err_len. err_len clears only on reset.
- Output handshake: a beat fires when m_tvalid && m_tready. On fire, acc shifts down 32 bytes and acc_cnt = max(acc_cnt - 32, 0).
- Outputs are driven directly from registers: m_tdata = acc[255:0].
- States:
  - FILL:
    - m_tvalid = (acc_cnt >= 32), with m_tkeep = all ones and m_tlast = 0.
    - in_ready = (acc_cnt < 32) || m_tready.
    - An accepted chunk with in_last = 1 moves the state to FLUSH.
  - FLUSH:
    - in_ready = 0; m_tvalid = 1.
    - m_tkeep = (1 << min(acc_cnt,32)) - 1.
    - m_tlast = (acc_cnt <= 32).
    - A fire with m_tlast = 1 returns the state to FILL with acc_cnt = 0.
- Simultaneous fire and accept: both apply in the same cycle. The new acc_cnt = acc_cnt - 32 + in_bytes, which is always below 64.
- Zero-length chunk: in_bytes = 0 with in_last = 1 is legal.
  - If the accumulator is empty on entering FLUSH, a single beat is emitted with m_tkeep = 0 and m_tlast = 1.
  - This preserves the packet boundary.
- Latency: a chunk that completes a beat, or ends a packet, is visible on m_tdata in the cycle after acceptance.
- Backpressure: m_tdata, m_tkeep and m_tlast are held stable while m_tvalid && !m_tready.
- Packet separation: no beat ever contains bytes from two packets.

Optional Feature:
- Macro: PACKER_STATS_EN.
- Defined:
  - Adds outputs stat_pkts[31:0] and stat_bytes[31:0], both reset to 0.
  - stat_pkts increments on every fire with m_tlast = 1.
  - stat_bytes adds popcount(m_tkeep) on every fire.
  - Both counters wrap modulo 2^32.
- Undefined: neither port nor counter logic exists; the rest of the behaviour is identical.

Test Plan:
1. Full chunks, 4 chunks of 32 bytes (pattern 0x00..0x7F), last on the 4th, m_tready = 1:
   - 4 beats, all tkeep = 0xFFFFFFFF.
   - tlast only on beat 4; bytes in order.
2. Small chunks, 10-byte chunks ×7, last on the 7th (70 bytes):
   - Beats with tkeep 0xFFFFFFFF, 0xFFFFFFFF, then 0x0000003F with tlast.
   - Byte 64 lands in lane 0 of beat 3.
3. Downstream stall, m_tready = 0 for 20 cycles while feeding 32-byte chunks:
   - in_ready drops once acc_cnt >= 32.
   - No data loss; m_tdata is stable during the stall.
   - Releasing m_tready drains in order.
4. Simultaneous fire/accept, acc_cnt = 32 with m_tready = 1, then a 0-byte chunk with in_last:
   - Beat fires with tlast = 0.
   - Next cycle a beat with tkeep = 0 and tlast = 1.
5. Clamp and error, in_bytes = 40:
   - Exactly 32 bytes are appended and err_len = 1 next cycle.
   - err_len stays 1 until reset.
6. Reset mid-packet, reset after 45 bytes buffered:
   - Next cycle m_tvalid = 0, acc_cnt = 0.
   - A following 5-byte last chunk emits tkeep = 0x1F with tlast.
   - With PACKER_STATS_EN defined: stat_pkts = 1, stat_bytes = 5.

Source files
------------

// File: rtl/compressed_stream_packer.sv
// Repacks 0..32-byte chunks into dense 256-bit AXI-Stream beats, one packet per beat run.
// Optional PACKER_STATS_EN adds packet/byte counters on the output handshake.
module compressed_stream_packer #(
  parameter int BURST_WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BURST_WIDTH-1:0] in_data,
  input  logic [5:0]             in_bytes,
  input  logic                   in_last,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [BURST_WIDTH-1:0] m_tdata,
  output logic [31:0]            m_tkeep,
  output logic                   m_tlast,
`ifdef PACKER_STATS_EN
  output logic [31:0]            stat_pkts,
  output logic [31:0]            stat_bytes,
`endif
  output logic                   err_len
);

  typedef enum logic {FILL, FLUSH} state_t;

  state_t                   state, state_nxt;
  logic [2*BURST_WIDTH-1:0] acc, acc_fired, acc_nxt;
  logic [6:0]               acc_cnt, cnt_fired, cnt_nxt;
  logic                     ready_en;
  logic                     fire, accept;
  logic [5:0]               nbytes;
  logic [BURST_WIDTH-1:0]   chunk;

  assign m_tdata = acc[BURST_WIDTH-1:0];
  assign fire    = m_tvalid && m_tready;
  assign accept  = in_valid && in_ready;
  assign nbytes  = (in_bytes > 6'd32) ? 6'd32 : in_bytes;
  // Lanes above the byte count are zeroed so the accumulator stays clean past acc_cnt.
  assign chunk   = in_data & ~({BURST_WIDTH{1'b1}} << {nbytes, 3'b000});

  always_comb begin
    m_tvalid  = 1'b0;
    m_tkeep   = '0;
    m_tlast   = 1'b0;
    in_ready  = 1'b0;
    state_nxt = state;
    case (state)
      FILL: begin
        m_tvalid = (acc_cnt >= 7'd32);
        m_tkeep  = m_tvalid ? '1 : '0;
        in_ready = ready_en && ((acc_cnt < 7'd32) || m_tready);
        if (accept && in_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        m_tvalid = 1'b1;
        m_tkeep  = (acc_cnt >= 7'd32) ? '1 : ~(32'hFFFF_FFFF << acc_cnt[4:0]);
        m_tlast  = (acc_cnt <= 7'd32);
        if (fire && m_tlast) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    acc_fired = fire ? (acc >> BURST_WIDTH) : acc;
    cnt_fired = acc_cnt;
    if (fire) cnt_fired = (acc_cnt > 7'd32) ? (acc_cnt - 7'd32) : 7'd0;
    acc_nxt = acc_fired;
    cnt_nxt = cnt_fired;
    if (accept) begin
      acc_nxt = acc_fired | ({{BURST_WIDTH{1'b0}}, chunk} << {cnt_fired, 3'b000});
      cnt_nxt = cnt_fired + {1'b0, nbytes};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FILL;
      acc      <= '0;
      acc_cnt  <= '0;
      err_len  <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      acc_cnt  <= cnt_nxt;
      ready_en <= 1'b1;
      if (accept && (in_bytes > 6'd32)) err_len <= 1'b1;
    end
  end

`ifdef PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_pkts  <= '0;
      stat_bytes <= '0;
    end else if (fire) begin
      stat_bytes <= stat_bytes + 32'($countones(m_tkeep));
      if (m_tlast) stat_pkts <= stat_pkts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_compressed_stream_packer.sv
// Scoreboard bench for compressed_stream_packer: a byte-level packet model predicts every beat.
module tb_compressed_stream_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic [5:0]   in_bytes;
  logic         in_last;
  logic         m_tvalid;
  logic         m_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic         m_tlast;
  logic         err_len;
`ifdef PACKER_STATS_EN
  logic [31:0]  stat_pkts;
  logic [31:0]  stat_bytes;
`endif

  always #5 clk = ~clk;

  compressed_stream_packer #(.BURST_WIDTH(256)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_bytes (in_bytes),
    .in_last  (in_last),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
`ifdef PACKER_STATS_EN
    .stat_pkts (stat_pkts),
    .stat_bytes(stat_bytes),
`endif
    .err_len  (err_len)
  );

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
  } beat_t;

  beat_t        exp_q[$];
  logic [7:0]   pend[$];
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   seq;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_beat(input int n, input logic last);
    beat_t b;
    b.data = '0;
    for (int i = 0; i < n; i++) b.data[i*8 +: 8] = pend.pop_front();
    b.keep = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    b.last = last;
    exp_q.push_back(b);
  endfunction

  // Monitor: samples on the falling edge what the next rising edge will commit.
  initial begin
    logic         hold_vld;
    logic [255:0] hold_dat;
    logic [31:0]  hold_keep;
    logic         hold_last;
    hold_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend.delete();
        exp_q.delete();
        hold_vld = 1'b0;
      end else begin
        if (hold_vld) begin
          check("hold_valid", m_tvalid, 1'b1);
          check("hold_data", m_tdata, hold_dat);
          check("hold_keep", m_tkeep, hold_keep);
          check("hold_last", m_tlast, hold_last);
        end
        hold_vld  = m_tvalid && !m_tready;
        hold_dat  = m_tdata;
        hold_keep = m_tkeep;
        hold_last = m_tlast;
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1'b1, 1'b0);
          end else begin
            beat_t        b;
            logic [255:0] m;
            b = exp_q.pop_front();
            for (int i = 0; i < 32; i++) m[i*8 +: 8] = {8{b.keep[i]}};
            check("beat_data", m_tdata & m, b.data);
            check("beat_keep", m_tkeep, b.keep);
            check("beat_last", m_tlast, b.last);
          end
        end
        if (in_valid && in_ready) begin
          int n;
          n = (in_bytes > 6'd32) ? 32 : int'(in_bytes);
          for (int i = 0; i < n; i++) pend.push_back(in_data[i*8 +: 8]);
          if (!in_last) begin
            while (pend.size() >= 32) push_beat(32, 1'b0);
          end else begin
            while (pend.size() > 32) push_beat(32, 1'b0);
            push_beat(pend.size(), 1'b1);
          end
        end
      end
    end
  end

  task automatic send(input int nb, input logic last);
    int n;
    bit ok;
    n = (nb > 32) ? 32 : nb;
    in_bytes = 6'(nb);
    in_last  = last;
    for (int i = 0; i < 32; i++) in_data[i*8 +: 8] = (i < n) ? (seq + 8'(i)) : 8'hEE;
    seq = seq + 8'(n);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_bytes = '0;
    in_last  = 1'b0;
    m_tready = 1'b1;
    seq      = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tlast", m_tlast, 1'b0);
    check("rst_tkeep", m_tkeep, 32'h0);
    check("rst_err_len", err_len, 1'b0);
`ifdef PACKER_STATS_EN
    check("rst_stat_pkts", stat_pkts, 32'h0);
    check("rst_stat_bytes", stat_bytes, 32'h0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Full 32-byte chunks, pattern 0x00..0x7F
    seq = 8'h00;
    for (int i = 0; i < 4; i++) send(32, i == 3);
    drain();

    // 10-byte chunks x7 -> 32, 32, 6 bytes
    seq = 8'h00;
    for (int i = 0; i < 7; i++) send(10, i == 6);
    drain();

    // Downstream stall for 20 cycles
    m_tready = 1'b0;
    send(32, 1'b0);
    @(negedge clk);
    check("stall_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    fork
      begin
        repeat (20) @(posedge clk);
        #1 m_tready = 1'b1;
      end
      begin
        send(32, 1'b0);
        send(32, 1'b1);
      end
    join
    drain();

    // Fire and accept together at acc_cnt = 32, then an empty last chunk
    m_tready = 1'b1;
    send(32, 1'b0);
    send(0, 1'b1);
    drain();

    // Length clamp and sticky error
    @(negedge clk);
    check("err_len_before", err_len, 1'b0);
    @(posedge clk); #1;
    send(40, 1'b0);
    @(negedge clk);
    check("err_len_set", err_len, 1'b1);
    @(posedge clk); #1;
    send(8, 1'b1);
    drain();
    @(negedge clk);
    check("err_len_sticky", err_len, 1'b1);
    @(posedge clk); #1;

    // Reset with 45 bytes buffered
    m_tready = 1'b0;
    send(13, 1'b0);
    send(32, 1'b0);
    @(negedge clk);
    check("pre_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_tvalid", m_tvalid, 1'b0);
    check("midrst_err_len", err_len, 1'b0);
    m_tready = 1'b1;
    @(posedge clk); #1;
    send(5, 1'b1);
    drain();
`ifdef PACKER_STATS_EN
    check("stat_pkts", stat_pkts, 32'd1);
    check("stat_bytes", stat_bytes, 32'd5);
`endif
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
